// File: rtl/sobel_line_buffer_if.sv
// Pixel-stream bundle between the raster source, sobel_line_buffer and the
// downstream Sobel window controller.
interface sobel_line_buffer_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   frame_start_i;
  logic                   px_rdy_i;
  logic [PIXEL_WIDTH-1:0] in_px_i;
  logic                   in_ready_o;
  logic                   start_sobel_o;
  logic                   px_rdy_o;
  logic [PIXEL_WIDTH-1:0] out_px_o;
  logic                   frame_done_o;

  // The pixel source drives the inputs and observes the emitted triples.
  modport master (
    output frame_start_i, px_rdy_i, in_px_i,
    input  in_ready_o, start_sobel_o, px_rdy_o, out_px_o, frame_done_o
  );

  modport slave (
    input  frame_start_i, px_rdy_i, in_px_i,
    output in_ready_o, start_sobel_o, px_rdy_o, out_px_o, frame_done_o
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer that serialises vertical pixel triples for the Sobel window.
// Optional macro LINEBUF_TOP_REPLICATE_EN: rows 0/1 also emit, replicating the top border.
module sobel_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  sobel_line_buffer_if.slave bus
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    EMIT0,
    EMIT1,
    EMIT2,
    ROW_GAP
  } state_t;

  state_t                 state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [PIXEL_WIDTH-1:0] mid_q;
  logic [PIXEL_WIDTH-1:0] bot_q;
  logic                   last_col_q;
  logic                   last_row_q;

  logic                   in_ready_q;
  logic                   start_sobel_q;
  logic                   px_rdy_q;
  logic [PIXEL_WIDTH-1:0] out_px_q;
  logic                   frame_done_q;

  // lb0 holds row y-2, lb1 holds row y-1 at every column.
  logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];

  logic                   accept;
  logic                   emit_row;
  logic [PIXEL_WIDTH-1:0] top_w;
  logic [PIXEL_WIDTH-1:0] mid_w;
  logic [PIXEL_WIDTH-1:0] bot_w;

  // A frame restart outranks a simultaneous pixel.
  assign accept = bus.px_rdy_i && in_ready_q && !bus.frame_start_i;

  // NOTE: every signal written here gets a value on every path, otherwise
  // synthesis infers a latch to hold the missing case.
  always_comb begin
    bot_w = bus.in_px_i;
`ifdef LINEBUF_TOP_REPLICATE_EN
    emit_row = 1'b1;
    if (y == '0) begin
      top_w = bus.in_px_i;
      mid_w = bus.in_px_i;
    end else if (y == YW'(1)) begin
      top_w = lb1[x];
      mid_w = lb1[x];
    end else begin
      top_w = lb0[x];
      mid_w = lb1[x];
    end
`else
    emit_row = (y >= YW'(2));
    top_w    = lb0[x];
    mid_w    = lb1[x];
`endif
  end

  // NOTE: the line buffers are deliberately left out of reset; a resettable
  // array cannot map onto RAM, and rows y<2 never expose stale contents.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0[x] <= lb1[x];
      lb1[x] <= bus.in_px_i;
    end
  end

  // NOTE: all state and outputs use non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      mid_q         <= '0;
      bot_q         <= '0;
      last_col_q    <= 1'b0;
      last_row_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      start_sobel_q <= 1'b0;
      px_rdy_q      <= 1'b0;
      out_px_q      <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      px_rdy_q     <= 1'b0;
      out_px_q     <= '0;
      frame_done_q <= 1'b0;

      if (bus.frame_start_i) begin
        state         <= IDLE;
        x             <= '0;
        y             <= '0;
        in_ready_q    <= 1'b1;
        start_sobel_q <= 1'b0;
      end else begin
        if (accept) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end

        unique case (state)
          IDLE, EMIT2: begin
            if (state == EMIT2 && last_col_q) begin
              state         <= ROW_GAP;
              in_ready_q    <= 1'b0;
              start_sobel_q <= 1'b0;
              frame_done_q  <= last_row_q;
            end else if (accept && emit_row) begin
              state         <= EMIT0;
              in_ready_q    <= 1'b0;
              start_sobel_q <= 1'b1;
              px_rdy_q      <= 1'b1;
              out_px_q      <= top_w;
              mid_q         <= mid_w;
              bot_q         <= bot_w;
              last_col_q    <= (x == X_LAST);
              last_row_q    <= (y == Y_LAST);
            end else begin
              state      <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
          EMIT0: begin
            state    <= EMIT1;
            px_rdy_q <= 1'b1;
            out_px_q <= mid_q;
          end
          EMIT1: begin
            // The next pixel may be taken during the final beat unless the row ends.
            state      <= EMIT2;
            px_rdy_q   <= 1'b1;
            out_px_q   <= bot_q;
            in_ready_q <= !last_col_q;
          end
          ROW_GAP: begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
          end
          default: begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready_o    = in_ready_q;
  assign bus.start_sobel_o = start_sobel_q;
  assign bus.px_rdy_o      = px_rdy_q;
  assign bus.out_px_o      = out_px_q;
  assign bus.frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer on a 4x4 image with pixel = 16*y+x.
// Honours LINEBUF_TOP_REPLICATE_EN when the design is built with it.
module tb_sobel_line_buffer;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef LINEBUF_TOP_REPLICATE_EN
  localparam int FIRST_EMIT_ROW = 0;
`else
  localparam int FIRST_EMIT_ROW = 2;
`endif
  localparam int EMIT_ROWS = H - FIRST_EMIT_ROW;

  logic clk_i    = 1'b0;
  logic nreset_i = 1'b0;

  sobel_line_buffer_if #(.PIXEL_WIDTH(PW)) bus ();

  sobel_line_buffer #(
    .PIXEL_WIDTH(PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [PW-1:0] exp_q [$];
  int mx, my;
  int cycle, last_acc_cycle;
  int frame_acc, frame_beats, frame_gaps, frame_dones, row_beats;
  bit strict_rate;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int px, input int py);
    return PW'(16 * py + px);
  endfunction

  // Expected triple for an accepted pixel comes straight from image coordinates.
  task automatic model_accept();
    if (my >= FIRST_EMIT_ROW) begin
      exp_q.push_back(pix(mx, (my >= 2) ? my - 2 : 0));
      exp_q.push_back(pix(mx, (my >= 1) ? my - 1 : 0));
      exp_q.push_back(pix(mx, my));
    end
    if (strict_rate && mx > 0 && my >= FIRST_EMIT_ROW)
      check("accept_interval", 32'(cycle - last_acc_cycle), 32'd3);
    last_acc_cycle = cycle;
    frame_acc++;
    if (mx == W - 1) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    bus.in_px_i = pix(mx, my);
  endtask

  // One clock: monitor outputs at the falling edge, then update the model after the rising edge.
  task automatic step();
    bit acc;
    @(negedge clk_i);
    if (bus.px_rdy_o) begin
      if (exp_q.size() == 0) check("spurious_beat", 32'(bus.px_rdy_o), 32'd0);
      else                   check("beat_px", 32'(bus.out_px_o), 32'(exp_q.pop_front()));
      check("beat_start_sobel", 32'(bus.start_sobel_o), 32'd1);
      frame_beats++;
      row_beats++;
    end else if (bus.in_ready_o) begin
      check("idle_start_sobel", 32'(bus.start_sobel_o), 32'(row_beats != 0));
    end else begin
      frame_gaps++;
      check("gap_start_sobel", 32'(bus.start_sobel_o), 32'd0);
      check("row_beat_count", 32'(row_beats), 32'(3 * W));
      row_beats = 0;
    end
    if (bus.frame_done_o) begin
      frame_dones++;
      check("done_in_gap", 32'(bus.in_ready_o | bus.px_rdy_o), 32'd0);
    end
    acc = bus.px_rdy_i && bus.in_ready_o && !bus.frame_start_i;
    @(posedge clk_i);
    #1;
    cycle++;
    if (bus.frame_start_i) begin
      bus.frame_start_i = 1'b0;
      mx = 0;
      my = 0;
      exp_q.delete();
      row_beats   = 0;
      bus.in_px_i = pix(0, 0);
    end else if (acc) begin
      model_accept();
    end
  endtask

  task automatic run_frame(input bit bubbles);
    frame_acc   = 0;
    frame_beats = 0;
    frame_gaps  = 0;
    frame_dones = 0;
    strict_rate = !bubbles;
    for (int i = 0; i < 2000 && frame_acc < W * H; i++) begin
      bus.px_rdy_i = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    check("frame_accepts", 32'(frame_acc), 32'(W * H));
    bus.px_rdy_i = 1'b0;
    repeat (8) step();
    check("frame_beats", 32'(frame_beats), 32'(3 * W * EMIT_ROWS));
    check("frame_gaps", 32'(frame_gaps), 32'(EMIT_ROWS));
    check("frame_done_pulses", 32'(frame_dones), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int target;
    bus.frame_start_i = 1'b0;
    bus.px_rdy_i      = 1'b0;
    mx = 0;
    my = 0;
    bus.in_px_i = pix(0, 0);
    cycle = 0;
    last_acc_cycle = 0;
    row_beats = 0;
    strict_rate = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    check("rst_px_rdy", 32'(bus.px_rdy_o), 32'd0);
    check("rst_start_sobel", 32'(bus.start_sobel_o), 32'd0);
    check("rst_out_px", 32'(bus.out_px_o), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done_o), 32'd0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);

    // Full-rate frame, then a frame with random input bubbles
    run_frame(1'b0);
    run_frame(1'b1);
    run_frame(1'b0);

    // Reset while the middle beat of the first row-2 triple is on the bus
    frame_acc    = 0;
    frame_beats  = 0;
    strict_rate  = 1'b0;
    bus.px_rdy_i = 1'b1;
    target = 3 * W * (2 - FIRST_EMIT_ROW) + 1;
    for (int i = 0; i < 500 && frame_beats < target; i++) step();
    check("rst_mid_reach", 32'(frame_beats), 32'(target));
    check("pre_rst_px_rdy", 32'(bus.px_rdy_o), 32'd1);
    check("pre_rst_mid_px", 32'(bus.out_px_o), 32'(pix(0, 1)));
    nreset_i = 1'b0;
    #1;
    check("mid_rst_px_rdy", 32'(bus.px_rdy_o), 32'd0);
    check("mid_rst_start_sobel", 32'(bus.start_sobel_o), 32'd0);
    check("mid_rst_out_px", 32'(bus.out_px_o), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    exp_q.delete();
    mx = 0;
    my = 0;
    row_beats   = 0;
    bus.in_px_i = pix(0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    nreset_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rerst_in_ready", 32'(bus.in_ready_o), 32'd1);
    run_frame(1'b0);

    // frame_start_i with a simultaneous valid pixel at (2,1)
    strict_rate  = 1'b0;
    bus.px_rdy_i = 1'b1;
    for (int i = 0; i < 500 && !(mx == 2 && my == 1); i++) step();
    check("fs_reach_x", 32'(mx), 32'd2);
    check("fs_reach_y", 32'(my), 32'd1);
    bus.frame_start_i = 1'b1;
    step();
    check("fs_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("fs_start_sobel", 32'(bus.start_sobel_o), 32'd0);
    run_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
